// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch-shift modes, one-cycle latency,
// valid/ready on both sides with a one-entry skid so a stalled consumer never loses an item.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o
);

  localparam int E = OUT_W - IN_W;

  generate
    if (IN_W < 2) begin : g_bad_in_w
      $error("imm_extend_pipe: IN_W must be at least 2");
    end
    if (SHIFT < 0) begin : g_bad_shift
      $error("imm_extend_pipe: SHIFT must be non-negative");
    end
    if (OUT_W < IN_W + SHIFT) begin : g_bad_out_w
      $error("imm_extend_pipe: OUT_W must be at least IN_W + SHIFT");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext;

  // Bits above IN_W replicate the sign (sext) or stay zero (zext).
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext_bit
      if (gi < IN_W) begin : g_low
        assign sext[gi] = data_i[gi];
        assign zext[gi] = data_i[gi];
      end else begin : g_high
        assign sext[gi] = data_i[IN_W-1];
        assign zext[gi] = 1'b0;
      end
    end
  endgenerate

  // Shifting the widened values cannot drop bits because OUT_W >= IN_W + SHIFT.
  always_comb begin
    ext = sext;
    case (mode_i)
      2'd0:    ext = sext;
      2'd1:    ext = zext;
      2'd2:    ext = zext << E;
      2'd3:    ext = sext << SHIFT;
      default: ext = sext;
    endcase
  end

  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_valid;
  logic             acc;
  logic             drain;

  // ready_o depends only on the skid register and reset, never on ready_i.
  assign ready_o = !rst_i && !skid_valid;
  assign acc     = valid_i && ready_o;
  assign drain   = !out_valid || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_data  <= ext;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_data  <= ext;
      skid_valid <= 1'b1;
    end
  end

  assign data_o  = out_data;
  assign valid_o = out_valid;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16->32 instance plus an 8->12 (SHIFT=1) instance.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] data_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;

  imm_extend_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
  );

  // swept-parameter instance
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [1:0]  s_mode_i = 2'd0;
  logic [7:0]  s_data_i = '0;
  logic        s_valid_o;
  logic        s_ready_i = 1'b1;
  logic [11:0] s_data_o;

  imm_extend_pipe #(.IN_W(8), .OUT_W(12), .SHIFT(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .valid_i(s_valid_i), .ready_o(s_ready_o), .mode_i(s_mode_i),
    .data_i(s_data_i), .valid_o(s_valid_o), .ready_i(s_ready_i), .data_o(s_data_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // step one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [1:0] m, input logic [15:0] d, input logic [31:0] exp,
                        input string tag);
    check_eq({tag, " ready"}, {31'b0, ready_o}, 32'd1);
    mode_i  = m;
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check_eq({tag, " valid"}, {31'b0, valid_o}, 32'd1);
    check_eq({tag, " data"}, data_o, exp);
    tick();
  endtask

  task automatic single_s(input logic [1:0] m, input logic [7:0] d, input logic [11:0] exp,
                          input string tag);
    s_mode_i  = m;
    s_data_i  = d;
    s_valid_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
    check_eq({tag, " valid"}, {31'b0, s_valid_o}, 32'd1);
    check_eq({tag, " data"}, {20'b0, s_data_o}, {20'b0, exp});
    tick();
  endtask

  logic [1:0]  st_mode [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1};
  logic [15:0] st_data [8] = '{16'h0001, 16'hFFFF, 16'hABCD, 16'h8000,
                               16'h8000, 16'h0100, 16'h0001, 16'h7FFF};
  logic [31:0] st_exp  [8] = '{32'h00000001, 32'h0000FFFF, 32'hABCD0000, 32'hFFFE0000,
                               32'hFFFF8000, 32'h00000400, 32'h00010000, 32'h00007FFF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    tick();
    check_eq("rst valid_o", {31'b0, valid_o}, 32'd0);
    check_eq("rst data_o", data_o, 32'd0);
    check_eq("rst ready_o", {31'b0, ready_o}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post-rst ready_o", {31'b0, ready_o}, 32'd1);

    // single items, each mode
    single(2'd0, 16'h8001, 32'hFFFF8001, "m0 8001");
    single(2'd0, 16'h7FFF, 32'h00007FFF, "m0 7fff");
    single(2'd1, 16'h8001, 32'h00008001, "m1 8001");
    single(2'd2, 16'h1234, 32'h12340000, "m2 1234");
    single(2'd3, 16'hFFFF, 32'hFFFFFFFC, "m3 ffff");
    single(2'd3, 16'h0003, 32'h0000000C, "m3 0003");

    // streaming: one result per cycle, ready_o stays high
    for (int i = 0; i < 8; i++) begin
      mode_i  = st_mode[i];
      data_i  = st_data[i];
      valid_i = 1'b1;
      check_eq($sformatf("stream%0d ready", i), {31'b0, ready_o}, 32'd1);
      tick();
      check_eq($sformatf("stream%0d valid", i), {31'b0, valid_o}, 32'd1);
      check_eq($sformatf("stream%0d data", i), data_o, st_exp[i]);
    end
    valid_i = 1'b0;
    tick();
    check_eq("stream drained", {31'b0, valid_o}, 32'd0);

    // back-pressure: A on output, B in skid, C held by source
    ready_i = 1'b0;
    mode_i = 2'd0; data_i = 16'h1111; valid_i = 1'b1;
    tick();
    check_eq("bp A out", data_o, 32'h00001111);
    mode_i = 2'd1; data_i = 16'h8888;
    tick();
    check_eq("bp A held", data_o, 32'h00001111);
    check_eq("bp ready low", {31'b0, ready_o}, 32'd0);
    mode_i = 2'd2; data_i = 16'h00C3;
    tick();
    check_eq("bp A still held", data_o, 32'h00001111);
    check_eq("bp valid held", {31'b0, valid_o}, 32'd1);
    check_eq("bp ready still low", {31'b0, ready_o}, 32'd0);
    ready_i = 1'b1;
    tick();
    check_eq("bp B out", data_o, 32'h00008888);
    check_eq("bp ready back", {31'b0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    check_eq("bp C out", data_o, 32'h00C30000);
    check_eq("bp C valid", {31'b0, valid_o}, 32'd1);
    tick();
    check_eq("bp no dup", {31'b0, valid_o}, 32'd0);

    // reset with output and skid both full
    ready_i = 1'b0;
    mode_i = 2'd0; data_i = 16'h4444; valid_i = 1'b1;
    tick();
    data_i = 16'h5555;
    tick();
    valid_i = 1'b0;
    check_eq("mid full valid", {31'b0, valid_o}, 32'd1);
    check_eq("mid full ready", {31'b0, ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid rst valid_o", {31'b0, valid_o}, 32'd0);
    check_eq("mid rst data_o", data_o, 32'd0);
    check_eq("mid rst ready_o", {31'b0, ready_o}, 32'd1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("mid rst quiet%0d", i), {31'b0, valid_o}, 32'd0);
    end

    // parameter sweep instance
    single_s(2'd3, 8'h80, 12'hF00, "sw m3 80");
    single_s(2'd2, 8'hA5, 12'hA50, "sw m2 a5");
    single_s(2'd0, 8'h7F, 12'h07F, "sw m0 7f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
